ram_port_ctrl: RTL

Request/response front-end for port A of the infrastructure BRAM (ram_infra). Converts a valid/ready request stream (read or byte-masked write) into BRAM port signals, tracks the fixed BRAM read latency, and returns read data through a credit-protected response FIFO so that response backpressure never loses data. It sits directly upstream of ram_infra port A; a bus adapter or DMA engine drives its request side.

---
 rtl/ram_port_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_port_ctrl.sv
// rtl/ram_port_ctrl.sv - valid/ready request front-end for BRAM port A with credit-protected read response FIFO
// Optional feature macro: RAM_PORT_CTRL_ALIGN_CHECK_EN (misaligned requests answered with rsp_err=1, no BRAM access)
module ram_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clka,
    input  logic                    rsta,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    ena,
    output logic [DATA_WIDTH/8-1:0] wea,
    output logic [ADDR_WIDTH-1:0]   addra,
    output logic [DATA_WIDTH-1:0]   dina,
    input  logic [DATA_WIDTH-1:0]   douta
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(RSP_DEPTH - 1);

    logic [CW-1:0]         credit_used;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  fifo_err;
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [RD_LATENCY-1:0] pipe_err;
    logic                  misaligned;
    logic                  accept;
    logic                  track;
    logic                  push;
    logic                  pop;

`ifdef RAM_PORT_CTRL_ALIGN_CHECK_EN
    localparam int BE_LSB = $clog2(DATA_WIDTH / 8);
    if (BE_LSB > 0) begin : g_align
        assign misaligned = |req_addr[BE_LSB-1:0];
    end else begin : g_no_align
        assign misaligned = 1'b0;
    end
`else
    assign misaligned = 1'b0;
`endif

    // Credits count reads in flight plus FIFO entries, so every accepted read has a guaranteed slot
    assign req_ready = !rsta && (credit_used < CREDIT_MAX);
    assign accept    = req_valid && req_ready;
    assign ena       = accept && !misaligned;
    assign wea       = (ena && req_we) ? req_be : '0;
    assign addra     = req_addr;
    assign dina      = req_wdata;
    // Reads, and misaligned requests of either kind, produce exactly one response
    assign track     = accept && (!req_we || misaligned);
    assign push      = pipe_vld[RD_LATENCY-1];
    assign rsp_valid = !rsta && (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;
    assign rsp_err   = rsp_valid && fifo_err[rd_ptr];
    assign busy      = !rsta && (credit_used != '0);

    // Latency pipeline: marks the edge at which douta belongs to a tracked request
    always_ff @(posedge clka) begin
        if (rsta) begin
            pipe_vld <= '0;
            pipe_err <= '0;
        end else begin
            pipe_vld[0] <= track;
            pipe_err[0] <= track && misaligned;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
            end
        end
    end

    // FIFO storage; error-tagged entries carry zero data instead of whatever douta holds
    always_ff @(posedge clka) begin
        if (push) begin
            fifo_data[wr_ptr] <= pipe_err[RD_LATENCY-1] ? '0 : douta;
            fifo_err[wr_ptr]  <= pipe_err[RD_LATENCY-1];
        end
    end

    // FIFO pointers and occupancy; push and pop on one edge cancel
    always_ff @(posedge clka) begin
        if (rsta) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!push && pop) fifo_count <= fifo_count - CW'(1);
        end
    end

    // Credit counter: taken when a response-producing request is accepted, returned on pop
    always_ff @(posedge clka) begin
        if (rsta) begin
            credit_used <= '0;
        end else if (track && !pop) begin
            credit_used <= credit_used + CW'(1);
        end else if (!track && pop) begin
            credit_used <= credit_used - CW'(1);
        end
    end
endmodule
